// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file bulk sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DUMP_RD,
    S_DUMP_HOLD,
    S_DONE
  } state_e;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  // X31 is hardwired zero in the regfile, so it doubles as the idle parking address.
  localparam logic [4:0] ZERO_REG = 5'd31;
  localparam logic [4:0] LAST_REG = 5'd30;

endpackage

// File: rtl/reg_index_counter.sv
// Register index walker: clears to 0, increments on request, flags the last index.
// Latency: index updates on the clock edge after clr_i/inc_i.
// Backpressure: none; increments beyond LAST are ignored, so the index never reaches X31.
// Ports: clk, reset (async active-low), clr_i, inc_i, idx_o, is_last_o.
module reg_index_counter
  import regfile_seq_pkg::*;
#(
  parameter int                ADDR_W = 5,
  parameter logic [ADDR_W-1:0] LAST   = ADDR_W'(LAST_REG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              is_last_o
);

  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i && (idx_q != LAST)) begin
      idx_d = idx_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o     = idx_q;
  assign is_last_o = (idx_q == LAST);

endmodule

// File: rtl/regfile_sequencer.sv
// Bulk initiator for the 32x64 regfile: FILL writes one value into X0..X30, DUMP streams X0..X30 out.
// Latency: FILL done 32 cycles after accept; DUMP word valid 1 cycle after its read address, 2 cycles/word best case.
// Backpressure: dump_ready low holds dump_valid/data/index stable; cmd_ready low (commands dropped) while busy.
// Ports: clk, reset (async active-low); cmd_valid/cmd_ready/cmd_op/fill_data command port; busy, done status;
//        WriteRegister/WriteData/RegWrite/ReadRegister1/ReadData1 regfile pins; dump_valid/dump_ready/dump_data/dump_index stream.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] ReadRegister1,
  input  logic [DATA_W-1:0] ReadData1,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index
);

  localparam logic [ADDR_W-1:0] PARK_REG = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic [ADDR_W-1:0] dump_index_q, dump_index_d;

  logic              cnt_clr;
  logic              cnt_inc;
  logic [ADDR_W-1:0] idx;
  logic              is_last;

  reg_index_counter #(
    .ADDR_W (ADDR_W),
    .LAST   (LAST_IDX)
  ) u_idx (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .idx_o     (idx),
    .is_last_o (is_last)
  );

  // Next state and all bus-side outputs. Outputs decode from state_q only, so
  // asserting reset parks the bus immediately without waiting for a clock edge.
  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    dump_data_d   = dump_data_q;
    dump_index_d  = dump_index_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = PARK_REG;
    WriteData     = '0;
    ReadRegister1 = PARK_REG;
    dump_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          fill_d  = fill_data;
          cnt_clr = 1'b1;
          case (cmd_op)
            OP_FILL: state_d = S_FILL;
            OP_DUMP: state_d = S_DUMP_RD;
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_FILL: begin
        RegWrite      = 1'b1;
        WriteRegister = idx;
        WriteData     = fill_q;
        if (is_last) begin
          state_d = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      // ReadData1 is combinational from ReadRegister1, so the word is captured
      // on the same edge that leaves this state.
      S_DUMP_RD: begin
        ReadRegister1 = idx;
        dump_data_d   = ReadData1;
        dump_index_d  = idx;
        state_d       = S_DUMP_HOLD;
      end

      S_DUMP_HOLD: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = S_DUMP_RD;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      fill_q       <= '0;
      dump_data_q  <= '0;
      dump_index_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      dump_data_q  <= dump_data_d;
      dump_index_q <= dump_index_d;
    end
  end

  assign dump_data  = dump_data_q;
  assign dump_index = dump_index_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer with a behavioural 32x64 regfile attached.
// A cycle-count reference model predicts every output each cycle; literal checks pin the model.
module tb_regfile_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [63:0] fill_data;
  logic        busy, done;
  logic [4:0]  WriteRegister, ReadRegister1, dump_index;
  logic [63:0] WriteData, ReadData1, dump_data;
  logic        RegWrite, dump_valid, dump_ready;

  // bench-side preload port into the regfile model
  logic        pre_we;
  logic [4:0]  pre_wa;
  logic [63:0] pre_wd;

  logic [63:0] rf [0:31];
  logic [63:0] exp_rf [0:30];

  int vectors;
  int miscompares;
  int rdy_mode;
  int hold_cnt;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] dat;
  } word_t;

  logic [14:0] ctl;
  assign ctl = {cmd_ready, busy, done, RegWrite, dump_valid, WriteRegister, ReadRegister1};

  regfile_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .fill_data     (fill_data),
    .busy          (busy),
    .done          (done),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ReadRegister1 (ReadRegister1),
    .ReadData1     (ReadData1),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_data     (dump_data),
    .dump_index    (dump_index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // regfile model: X31 reads zero and ignores writes
  assign ReadData1 = (ReadRegister1 == 5'd31) ? 64'd0 : rf[ReadRegister1];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    forever begin
      @(posedge clk);
      if (RegWrite) begin
        if (WriteRegister != 5'd31) rf[WriteRegister] = WriteData;
      end else if (pre_we && pre_wa != 5'd31) begin
        rf[pre_wa] = pre_wd;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // dump_ready driver: 0 = always ready, 1 = random, 2 = stall 5 cycles on index 7
  initial begin
    dump_ready = 1'b1;
    hold_cnt   = 0;
    forever begin
      cyc();
      case (rdy_mode)
        1: dump_ready = 1'($urandom_range(0, 1));
        2: begin
          if (dump_valid && dump_index == 5'd7 && hold_cnt < 5) begin
            dump_ready = 1'b0;
            hold_cnt++;
          end else begin
            dump_ready = 1'b1;
          end
        end
        default: begin
          dump_ready = 1'b1;
          hold_cnt   = 0;
        end
      endcase
    end
  end

  // Reference model: counts cycles since accept (k=1 is the first cycle after
  // the accepting edge) and derives every output from the command rules.
  initial begin : model
    bit          m_active;
    bit          m_op;
    int          m_k, m_done_k, m_nv_k;
    logic [63:0] m_fill;
    word_t       m_words[$];
    bit          e_done, e_we, e_vld;
    logic [4:0]  e_wr, e_rr;
    m_active = 1'b0;
    m_op     = 1'b0;
    m_k      = 0;
    m_done_k = 0;
    m_nv_k   = 0;
    m_fill   = 64'd0;
    for (int i = 0; i < 31; i++) exp_rf[i] = 64'd0;
    forever begin
      @(negedge clk);
      if (pre_we && pre_wa < 5'd31) exp_rf[pre_wa] = pre_wd;
      e_done = 1'b0; e_we = 1'b0; e_vld = 1'b0; e_wr = 5'd31; e_rr = 5'd31;
      if (!reset || !m_active) begin
        m_active = 1'b0;
        chk("idle_ctl", 64'(ctl), 64'({1'b1, 1'b0, 3'b000, 5'd31, 5'd31}));
        if (reset && cmd_valid) begin
          m_active = 1'b1;
          m_k      = 1;
          m_op     = cmd_op;
          m_fill   = fill_data;
          m_words.delete();
          if (!cmd_op) begin
            m_done_k = 32;
          end else begin
            m_done_k = -1;
            m_nv_k   = 2;
            for (int i = 0; i < 31; i++) m_words.push_back('{5'(i), exp_rf[i]});
          end
        end
      end else begin
        e_done = (m_k == m_done_k);
        if (!m_op) begin
          e_we = (m_k <= 31);
          if (e_we) e_wr = 5'(m_k - 1);
        end else if (m_words.size() > 0) begin
          e_vld = (m_k >= m_nv_k);
          if (m_k == m_nv_k - 1) e_rr = m_words[0].idx;
        end
        chk("busy_ctl", 64'(ctl), 64'({1'b0, 1'b1, e_done, e_we, e_vld, e_wr, e_rr}));
        if (e_we) begin
          chk("wdata", WriteData, m_fill);
          exp_rf[m_k-1] = m_fill;
        end
        if (e_vld) begin
          chk("dump_index", 64'(dump_index), 64'(m_words[0].idx));
          chk("dump_data", dump_data, m_words[0].dat);
          if (dump_ready) begin
            void'(m_words.pop_front());
            m_nv_k = m_k + 2;
            if (m_words.size() == 0) m_done_k = m_k + 1;
          end
        end
        if (e_done) m_active = 1'b0;
        m_k++;
      end
    end
  end

  task automatic preload_pattern();
    for (int i = 0; i < 31; i++) begin
      pre_we = 1'b1;
      pre_wa = 5'(i);
      pre_wd = 64'(i) * 64'h1111;
      cyc();
    end
    pre_we = 1'b0;
    cyc();
  endtask

  // Issue one command from IDLE and wait for done; exp_k = 0 skips the cycle pin.
  task automatic run_cmd(input bit op, input logic [63:0] data, input int exp_k,
                         input int poke_k, input string tag);
    int k, nwe, ndone;
    bit found;
    cmd_valid = 1'b1;
    cmd_op    = op;
    fill_data = data;
    cyc();
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    fill_data = ~data;
    k = 1; nwe = 0; ndone = 0; found = 1'b0;
    while (!found && k <= 400) begin
      cmd_valid = (k == poke_k);
      if (k == poke_k) cmd_op = 1'b1;
      if (RegWrite) nwe++;
      if (done) begin
        found = 1'b1;
        ndone++;
      end else begin
        cyc();
        k++;
      end
    end
    cmd_valid = 1'b0;
    if (!found) begin
      chk({tag, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      if (exp_k > 0) chk({tag, "_done_cycle"}, 64'(k), 64'(exp_k));
      if (!op) chk({tag, "_write_cycles"}, 64'(nwe), 64'd31);
      repeat (3) begin
        cyc();
        if (done) ndone++;
      end
      chk({tag, "_done_pulses"}, 64'(ndone), 64'd1);
    end
  endtask

  initial begin : stim
    int  k;
    bit  op;
    vectors     = 0;
    miscompares = 0;
    rdy_mode    = 0;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 1'b0;
    fill_data   = 64'd0;
    pre_we      = 1'b0;
    pre_wa      = 5'd0;
    pre_wd      = 64'd0;

    // reset values
    #1;
    chk("rst_ctl", 64'(ctl), 64'({1'b1, 1'b0, 3'b000, 5'd31, 5'd31}));
    chk("rst_wdata", WriteData, 64'd0);
    chk("rst_dump_data", dump_data, 64'd0);
    chk("rst_dump_index", 64'(dump_index), 64'd0);
    repeat (2) cyc();
    reset = 1'b1;
    cyc();

    // FILL with readback
    run_cmd(1'b0, 64'hDEAD_BEEF_0123_4567, 32, 0, "fill");
    chk("rb_x0", rf[0], 64'hDEAD_BEEF_0123_4567);
    chk("rb_x15", rf[15], 64'hDEAD_BEEF_0123_4567);
    chk("rb_x30", rf[30], 64'hDEAD_BEEF_0123_4567);
    chk("rb_x31", rf[31], 64'd0);

    // DUMP, always ready
    preload_pattern();
    chk("pre_x30", rf[30], 64'h1FFFE);
    run_cmd(1'b1, 64'h0, 63, 0, "dump");

    // DUMP with a 5-cycle stall on index 7
    rdy_mode = 2;
    run_cmd(1'b1, 64'h0, 68, 0, "dump_bp");
    rdy_mode = 0;

    // command attempted during FILL is ignored
    run_cmd(1'b0, 64'h0123_4567_89AB_CDEF, 32, 5, "fill_busy");

    // reset in the cycle that would write X10
    preload_pattern();
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    fill_data = 64'hFF;
    cyc();
    cmd_valid = 1'b0;
    k = 0;
    while (!(RegWrite && WriteRegister == 5'd10) && k < 40) begin
      cyc();
      k++;
    end
    chk("midfill_reach_x10", 64'(k < 40), 64'd1);
    reset = 1'b0;
    #1;
    chk("midfill_rst_ctl", 64'({cmd_ready, busy, RegWrite, WriteRegister, dump_valid}),
        64'({1'b1, 1'b0, 1'b0, 5'd31, 1'b0}));
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    chk("midfill_x0", rf[0], 64'hFF);
    chk("midfill_x9", rf[9], 64'hFF);
    chk("midfill_x10", rf[10], 64'hAAAA);
    chk("midfill_x30", rf[30], 64'h1FFFE);
    chk("midfill_idle_done", 64'({cmd_ready, done}), 64'({1'b1, 1'b0}));
    run_cmd(1'b1, 64'h0, 63, 0, "dump_after_rst");

    // randomized commands with random dump backpressure
    rdy_mode = 1;
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) cyc();
      op = 1'($urandom_range(0, 1));
      run_cmd(op, {$urandom, $urandom}, op ? 0 : 32, 0, "rnd");
    end
    rdy_mode = 0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
